// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART scheduler state encoding and constants
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } uart_state_t;

  // tx_status level reported by the sender when it is not shifting
  localparam logic TX_IDLE = 1'b1;

  localparam logic [31:0] UART_TXD_ADDR    = 32'h4000_0018;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CTRL_ADDR   = 32'h4000_0020;

endpackage

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational round-robin pick starting after the last grant
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    // Walk last+1, last+2, ... wrapping, so the previous winner is checked last
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one UART sender between requesters, tracks launch and completion
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int TIMEOUT = 64,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   done,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  input  logic               tx_status,
  output logic               busy,
  output logic [IDX_W-1:0]   owner,
  output logic               err,
  input  logic               err_clr
);

  localparam int TMO_W = $clog2(TIMEOUT);

  uart_state_t      state, state_nx;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nx;
  logic [TMO_W-1:0] tmo_cnt, tmo_nx;
  logic [N_REQ-1:0] ack_nx, done_nx;
  logic             tx_en_nx, err_nx, tmo_hit;
  logic [7:0]       tx_data_nx, sel_byte;
  logic [IDX_W-1:0] owner_nx;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .last      (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_byte = req_data[8*i +: 8];
    end
  end

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_nx   = state;
    rr_ptr_nx  = rr_ptr;
    tmo_nx     = tmo_cnt;
    ack_nx     = '0;
    done_nx    = '0;
    tx_en_nx   = 1'b0;
    tx_data_nx = tx_data;
    owner_nx   = owner;
    tmo_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_status == TX_IDLE && grant_vld) begin
          tx_en_nx   = 1'b1;
          ack_nx     = grant;
          tx_data_nx = sel_byte;
          owner_nx   = grant_idx;
          rr_ptr_nx  = grant_idx;
          tmo_nx     = '0;
          state_nx   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // Sender going busy on the terminal count still counts as a clean launch
        if (tx_status != TX_IDLE) begin
          state_nx = ST_WAIT_DONE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          tmo_hit  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          tmo_nx = tmo_cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_status == TX_IDLE) begin
          done_nx  = N_REQ'(1) << owner;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    err_nx = err;
    if (tmo_hit) err_nx = 1'b1;
    if (err_clr) err_nx = 1'b0;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= IDX_W'(N_REQ - 1);
      tmo_cnt <= '0;
      ack     <= '0;
      done    <= '0;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
      owner   <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      rr_ptr  <= rr_ptr_nx;
      tmo_cnt <= tmo_nx;
      ack     <= ack_nx;
      done    <= done_nx;
      tx_en   <= tx_en_nx;
      tx_data <= tx_data_nx;
      owner   <= owner_nx;
      err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed bench with a transaction-level scheduler model
module tb_uart_tx_scheduler;

  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 64;
  localparam int IDX_W   = $clog2(N_REQ);

  logic               CLK;
  logic               Reset_n;
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   done;
  logic               tx_en;
  logic [7:0]         tx_data;
  logic               tx_status;
  logic               busy;
  logic [IDX_W-1:0]   owner;
  logic               err;
  logic               err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .done      (done),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_status (tx_status),
    .busy      (busy),
    .owner     (owner),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: a byte is "in flight" from its grant until the sender finishes it or never starts
  int               cyc = 0;
  int               m_launch_cyc, m_owner, m_last, m_c;
  logic             m_in_flight, m_sender_started, m_found, m_err, m_txen;
  logic [N_REQ-1:0] m_ack, m_done;
  logic [7:0]       m_data;

  always @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      m_in_flight = 1'b0; m_sender_started = 1'b0; m_err = 1'b0; m_txen = 1'b0;
      m_ack = '0; m_done = '0; m_data = 8'h00; m_owner = 0; m_last = N_REQ - 1;
      m_launch_cyc = 0;
    end else begin
      cyc = cyc + 1;
      m_ack = '0; m_done = '0; m_txen = 1'b0;
      if (!m_in_flight) begin
        if (tx_status && req != '0) begin
          m_found = 1'b0;
          for (int k = 1; k <= N_REQ; k++) begin
            m_c = (m_last + k) % N_REQ;
            if (!m_found && req[m_c]) begin m_found = 1'b1; m_owner = m_c; end
          end
          m_last = m_owner; m_ack[m_owner] = 1'b1; m_txen = 1'b1;
          m_data = req_data[8*m_owner +: 8];
          m_in_flight = 1'b1; m_sender_started = 1'b0; m_launch_cyc = cyc;
        end
      end else if (!m_sender_started) begin
        if (!tx_status) m_sender_started = 1'b1;
        else if (cyc - m_launch_cyc == TIMEOUT) begin m_err = 1'b1; m_in_flight = 1'b0; end
      end else if (tx_status) begin
        m_done[m_owner] = 1'b1; m_in_flight = 1'b0;
      end
      if (err_clr) m_err = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle advance goes through here, so the model is compared on each cycle
  task automatic tick();
    @(negedge CLK);
    chk("m_ack",   32'(ack),     32'(m_ack));
    chk("m_done",  32'(done),    32'(m_done));
    chk("m_tx_en", 32'(tx_en),   32'(m_txen));
    chk("m_data",  32'(tx_data), 32'(m_data));
    chk("m_busy",  32'(busy),    32'(m_in_flight));
    chk("m_owner", 32'(owner),   32'(m_owner));
    chk("m_err",   32'(err),     32'(m_err));
  endtask

  task automatic pulse_reset();
    Reset_n = 1'b0;
    tick(); tick();
    Reset_n = 1'b1;
  endtask

  // Wait for launch, act as the sender for low_len cycles, then wait for completion
  task automatic run_frame(input int low_len, input logic reraise,
                           input logic [N_REQ-1:0] exp_ack, input logic [7:0] exp_data);
    int   i = 0;
    logic seen = 1'b0;
    while (!seen && i < 20) begin
      tick(); i++;
      if (tx_en === 1'b1) begin
        seen = 1'b1;
        chk("launch_latency", 32'(i), 32'd1);
        chk("launch_ack", 32'(ack), 32'(exp_ack));
        chk("launch_data", 32'(tx_data), 32'(exp_data));
      end
    end
    chk("launch_seen", 32'(seen), 32'd1);
    req = req & ~exp_ack;
    tick();
    if (reraise) req = req | exp_ack;
    tx_status = 1'b0;
    repeat (low_len) tick();
    tx_status = 1'b1;
    i = 0; seen = 1'b0;
    while (!seen && i < 5) begin
      tick(); i++;
      if (done !== '0) begin
        seen = 1'b1;
        chk("done_vec", 32'(done), 32'(exp_ack));
        chk("done_busy", 32'(busy), 32'd0);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int cnt;
    Reset_n = 1'b0; req = '0; req_data = '0; tx_status = 1'b1; err_clr = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();

    // Single request from requester 0, sender busy for 160 cycles
    req_data[7:0] = 8'hA5; req = 2'b01;
    run_frame(160, 1'b0, 2'b01, 8'hA5);
    tick();

    // Reset during WAIT_DONE on a requester-1 frame
    req_data[15:8] = 8'h5A; req = 2'b10;
    tick();
    chk("t6_ack", 32'(ack), 32'b10);
    req = '0;
    tick(); tx_status = 1'b0;
    tick(); tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_data", 32'(tx_data), 32'd0);
    chk("t6_owner", 32'(owner), 32'd0);
    chk("t6_txen_ack", 32'({tx_en, ack, done}), 32'd0);
    tx_status = 1'b1;
    tick();
    Reset_n = 1'b1;
    cnt = 0;
    repeat (5) begin tick(); if (done !== '0) cnt++; end
    chk("t6_no_done", 32'(cnt), 32'd0);
    req_data[7:0] = 8'h3C; req = 2'b01;
    run_frame(7, 1'b0, 2'b01, 8'h3C);
    tick();

    // Fairness from fresh reset: both held, grants must alternate 0,1,0,1
    pulse_reset();
    req_data = {8'h22, 8'h11}; req = 2'b11;
    run_frame(5, 1'b1, 2'b01, 8'h11);
    run_frame(5, 1'b1, 2'b10, 8'h22);
    run_frame(5, 1'b1, 2'b01, 8'h11);
    run_frame(5, 1'b1, 2'b10, 8'h22);
    req = '0;
    tick(); tick();

    // Launch timeout: sender never leaves idle
    req_data[7:0] = 8'h99; req = 2'b01;
    tick();
    chk("t4_txen", 32'(tx_en), 32'd1);
    req = '0;
    cnt = 0;
    while (err !== 1'b1 && cnt < 100) begin tick(); cnt++; end
    chk("t4_tmo_cycles", 32'(cnt), 32'(TIMEOUT));
    chk("t4_busy", 32'(busy), 32'd0);
    tick(); tick();
    chk("t4_err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", 32'(err), 32'd0);
    tick();

    // Sender busy while requester 1 waits in IDLE
    tx_status = 1'b0;
    req_data[15:8] = 8'h77; req = 2'b10;
    cnt = 0;
    repeat (4) begin tick(); if (ack !== '0) cnt++; end
    chk("t5_no_grant", 32'(cnt), 32'd0);
    tx_status = 1'b1;
    tick();
    chk("t5_ack", 32'(ack), 32'b10);
    chk("t5_data", 32'(tx_data), 32'h77);
    chk("t5_owner", 32'(owner), 32'd1);
    req = '0;
    tick(); tx_status = 1'b0;
    repeat (3) tick();
    tx_status = 1'b1;
    tick();
    chk("t5_done", 32'(done), 32'b10);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
